issue_stage: RTL and testbench

- Dual-issue dispatch stage sitting in front of the even/odd execution pipes.
- Accepts one program-ordered instruction pair per handshake from decode and checks RAW/WAW hazards against an internal per-register scoreboard.
- Routes each instruction to its pipe as instr_even/instr_odd with a first_odd ordering flag, splitting or stalling the pair when required.
- Flushes held instructions on branch_taken returned by the odd pipe.

---
 rtl/issue_stage.sv | 167 ++++++++++++++++
 tb/tb_issue_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// Dual-issue dispatch stage: holds one decoded pair, checks it against a per-register
// latency scoreboard and routes it to the even/odd pipes, splitting or stalling as needed.
//
// state  | meaning
// EMPTY  | no held instruction; accepting a new pair
// PAIR   | H0/H1 held; dual, single or no issue this cycle
// SINGLE | only H0 held (younger half of a split pair)
module issue_stage #(
    parameter int NREG = 128,
    parameter int AW   = 7,
    parameter int LW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr0,
    input  logic [31:0]   in_instr1,
    input  logic          in_odd0,
    input  logic          in_odd1,
    input  logic [LW-1:0] in_lat0,
    input  logic [LW-1:0] in_lat1,
    input  logic          in_rw0,
    input  logic          in_rw1,
    input  logic [AW-1:0] in_rt0,
    input  logic [AW-1:0] in_rt1,
    input  logic [AW-1:0] in_ra0,
    input  logic [AW-1:0] in_rb0,
    input  logic [AW-1:0] in_rc0,
    input  logic [AW-1:0] in_ra1,
    input  logic [AW-1:0] in_rb1,
    input  logic [AW-1:0] in_rc1,
    input  logic [2:0]    in_use0,
    input  logic [2:0]    in_use1,
    input  logic          branch_taken,
    output logic [31:0]   instr_even,
    output logic [31:0]   instr_odd,
    output logic          first_odd,
    output logic          stall
);

    typedef struct packed {
        logic [31:0]   instr;
        logic          odd;
        logic [LW-1:0] lat;
        logic          rw;
        logic [AW-1:0] rt;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] rc;
        logic [2:0]    use_bits;
    } slot_t;

    typedef enum logic [1:0] {EMPTY, PAIR, SINGLE} state_t;

    state_t        state;
    slot_t         h0, h1, in0, in1;
    logic [LW-1:0] sb_cnt [NREG];

    logic h0_ready, h1_ready, raw_in_pair, waw_in_pair, dual_ok;
    logic issue0, issue1, hold_stall, capture;

    assign in0 = '{instr: in_instr0, odd: in_odd0, lat: in_lat0, rw: in_rw0, rt: in_rt0,
                   ra: in_ra0, rb: in_rb0, rc: in_rc0, use_bits: in_use0};
    assign in1 = '{instr: in_instr1, odd: in_odd1, lat: in_lat1, rw: in_rw1, rt: in_rt1,
                   ra: in_ra1, rb: in_rb1, rc: in_rc1, use_bits: in_use1};

    assign h0_ready = (!h0.use_bits[2] || sb_cnt[h0.ra] == '0) &&
                      (!h0.use_bits[1] || sb_cnt[h0.rb] == '0) &&
                      (!h0.use_bits[0] || sb_cnt[h0.rc] == '0);
    assign h1_ready = (!h1.use_bits[2] || sb_cnt[h1.ra] == '0) &&
                      (!h1.use_bits[1] || sb_cnt[h1.rb] == '0) &&
                      (!h1.use_bits[0] || sb_cnt[h1.rc] == '0);

    // The scoreboard cannot see the older slot's result yet, so intra-pair deps are explicit.
    assign raw_in_pair = h0.rw && ((h1.use_bits[2] && h1.ra == h0.rt) ||
                                   (h1.use_bits[1] && h1.rb == h0.rt) ||
                                   (h1.use_bits[0] && h1.rc == h0.rt));
    assign waw_in_pair = h0.rw && h1.rw && (h0.rt == h1.rt);
    assign dual_ok     = (h0.odd != h1.odd) && h0_ready && h1_ready &&
                         !raw_in_pair && !waw_in_pair;

    always_comb begin
        issue0     = 1'b0;
        issue1     = 1'b0;
        hold_stall = 1'b0;
        case (state)
            PAIR: begin
                if (dual_ok) begin
                    issue0 = 1'b1;
                    issue1 = 1'b1;
                end else if (h0_ready) begin
                    issue0 = 1'b1;
                end else begin
                    hold_stall = 1'b1;
                end
            end
            SINGLE: begin
                if (h0_ready) issue0 = 1'b1;
                else          hold_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready = (state == EMPTY) || (state == PAIR && dual_ok) ||
                      (state == SINGLE && h0_ready);
    assign capture  = in_valid && in_ready && !branch_taken;

    // Flushed instructions never issue, so they must not reserve their destinations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue1 && !branch_taken && h1.rw && h1.rt == AW'(i))
                    sb_cnt[i] <= h1.lat;
                else if (issue0 && !branch_taken && h0.rw && h0.rt == AW'(i))
                    sb_cnt[i] <= h0.lat;
                else if (sb_cnt[i] != '0)
                    sb_cnt[i] <= sb_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            h0         <= '0;
            h1         <= '0;
            instr_even <= '0;
            instr_odd  <= '0;
            first_odd  <= 1'b0;
            stall      <= 1'b0;
        end else begin
            instr_even <= '0;
            instr_odd  <= '0;
            first_odd  <= 1'b0;
            stall      <= 1'b0;
            if (branch_taken) begin
                state <= EMPTY;
            end else begin
                stall <= hold_stall;
                if (issue0) begin
                    if (h0.odd) instr_odd  <= h0.instr;
                    else        instr_even <= h0.instr;
                    first_odd <= h0.odd;
                end
                if (issue1) begin
                    if (h1.odd) instr_odd  <= h1.instr;
                    else        instr_even <= h1.instr;
                end
                if (capture) begin
                    h0    <= in0;
                    h1    <= in1;
                    state <= PAIR;
                end else if (state == PAIR && issue0 && !issue1) begin
                    h0    <= h1;
                    state <= SINGLE;
                end else if (issue0) begin
                    state <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: a vector table of pairs issued from idle, plus hand
// sequences for long RAW stalls, scoreboard carry-over, WAW, flushes and async reset.
module tb_issue_stage;

    logic        clk, reset, in_valid, in_ready, branch_taken;
    logic [31:0] in_instr0, in_instr1, instr_even, instr_odd;
    logic        in_odd0, in_odd1, in_rw0, in_rw1, first_odd, stall;
    logic [2:0]  in_lat0, in_lat1, in_use0, in_use1;
    logic [6:0]  in_rt0, in_rt1, in_ra0, in_rb0, in_rc0, in_ra1, in_rb1, in_rc1;

    int n_checks = 0;
    int n_fail   = 0;

    issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr0(in_instr0), .in_instr1(in_instr1), .in_odd0(in_odd0), .in_odd1(in_odd1),
        .in_lat0(in_lat0), .in_lat1(in_lat1), .in_rw0(in_rw0), .in_rw1(in_rw1),
        .in_rt0(in_rt0), .in_rt1(in_rt1), .in_ra0(in_ra0), .in_rb0(in_rb0), .in_rc0(in_rc0),
        .in_ra1(in_ra1), .in_rb1(in_rb1), .in_rc1(in_rc1), .in_use0(in_use0), .in_use1(in_use1),
        .branch_taken(branch_taken), .instr_even(instr_even), .instr_odd(instr_odd),
        .first_odd(first_odd), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        odd;
        logic [2:0]  lat;
        logic        rw;
        logic [6:0]  rt, ra, rb, rc;
        logic [2:0]  u;
    } ins_t;

    typedef struct {
        ins_t        s0, s1;
        logic [31:0] e1_even, e1_odd;
        logic        e1_fo, e1_st;
        logic [31:0] e2_even, e2_odd;
        logic        e2_fo, e2_st;
    } vec_t;

    function automatic ins_t mk(input logic [31:0] w, input logic odd, input logic [2:0] lat,
                                input logic rw, input logic [6:0] rt, input logic [6:0] ra,
                                input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] u);
        ins_t r;
        r.w = w; r.odd = odd; r.lat = lat; r.rw = rw; r.rt = rt;
        r.ra = ra; r.rb = rb; r.rc = rc; r.u = u;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t a, input ins_t b, input logic v);
        in_valid  = v;
        in_instr0 = a.w;  in_odd0 = a.odd; in_lat0 = a.lat; in_rw0 = a.rw; in_rt0 = a.rt;
        in_ra0 = a.ra; in_rb0 = a.rb; in_rc0 = a.rc; in_use0 = a.u;
        in_instr1 = b.w;  in_odd1 = b.odd; in_lat1 = b.lat; in_rw1 = b.rw; in_rt1 = b.rt;
        in_ra1 = b.ra; in_rb1 = b.rb; in_rc1 = b.rc; in_use1 = b.u;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    vec_t vt[9];
    ins_t nop_i;

    initial begin
        nop_i = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        //         s0                                               s1
        //         c1 even, odd, fo, st                c2 even, odd, fo, st
        vt[0] = '{mk(32'h1001, 0, 2, 1, 5, 1, 2, 0, 3'b110), mk(32'h1002, 1, 6, 1, 6, 3, 0, 0, 3'b100),
                  32'h1001, 32'h1002, 0, 0, 32'h0, 32'h0, 0, 0};
        vt[1] = '{mk(32'h2001, 0, 2, 1, 7, 1, 0, 0, 3'b100), mk(32'h2002, 0, 4, 1, 9, 2, 0, 0, 3'b100),
                  32'h2001, 32'h0, 0, 0, 32'h2002, 32'h0, 0, 0};
        vt[2] = '{mk(32'h3001, 1, 4, 1, 11, 1, 0, 0, 3'b100), mk(32'h3002, 0, 2, 1, 13, 2, 0, 0, 3'b100),
                  32'h3002, 32'h3001, 1, 0, 32'h0, 32'h0, 0, 0};
        vt[3] = '{mk(32'h4001, 1, 2, 1, 11, 1, 0, 0, 3'b100), mk(32'h4002, 1, 2, 1, 13, 2, 0, 0, 3'b100),
                  32'h0, 32'h4001, 1, 0, 32'h0, 32'h4002, 1, 0};
        vt[4] = '{mk(32'h5001, 0, 2, 1, 20, 1, 0, 0, 3'b100), mk(32'h5002, 1, 2, 1, 21, 0, 0, 20, 3'b001),
                  32'h5001, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1};
        vt[5] = '{mk(32'h6001, 0, 2, 0, 20, 1, 0, 0, 3'b100), mk(32'h6002, 1, 2, 1, 21, 0, 20, 0, 3'b010),
                  32'h6001, 32'h6002, 0, 0, 32'h0, 32'h0, 0, 0};
        vt[6] = '{mk(32'h7001, 0, 2, 1, 8, 1, 0, 0, 3'b100), mk(32'h7002, 1, 4, 1, 8, 2, 0, 0, 3'b100),
                  32'h7001, 32'h0, 0, 0, 32'h0, 32'h7002, 1, 0};
        vt[7] = '{mk(32'h8001, 0, 0, 1, 30, 1, 0, 0, 3'b100), mk(32'h8002, 1, 2, 1, 31, 30, 0, 0, 3'b100),
                  32'h8001, 32'h0, 0, 0, 32'h0, 32'h8002, 1, 0};
        vt[8] = '{mk(32'h9001, 0, 7, 1, 22, 1, 0, 0, 3'b100), mk(32'h9002, 1, 2, 1, 23, 22, 0, 0, 3'b000),
                  32'h9001, 32'h9002, 0, 0, 32'h0, 32'h0, 0, 0};

        branch_taken = 1'b0;
        drive(nop_i, nop_i, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_even", instr_even, 32'h0);
        chk("rst_odd", instr_odd, 32'h0);
        chk("rst_first_odd", 32'(first_odd), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].s0, vt[i].s1, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_c1_even", i), instr_even, vt[i].e1_even);
            chk($sformatf("v%0d_c1_odd", i), instr_odd, vt[i].e1_odd);
            chk($sformatf("v%0d_c1_fo", i), 32'(first_odd), 32'(vt[i].e1_fo));
            chk($sformatf("v%0d_c1_stall", i), 32'(stall), 32'(vt[i].e1_st));
            @(negedge clk);
            chk($sformatf("v%0d_c2_even", i), instr_even, vt[i].e2_even);
            chk($sformatf("v%0d_c2_odd", i), instr_odd, vt[i].e2_odd);
            chk($sformatf("v%0d_c2_fo", i), 32'(first_odd), 32'(vt[i].e2_fo));
            chk($sformatf("v%0d_c2_stall", i), 32'(stall), 32'(vt[i].e2_st));
            idle(12);
        end

        // RAW on an FP result: 7 stall cycles, younger issues on the 8th
        drive(mk(32'hA001, 0, 7, 1, 10, 1, 0, 0, 3'b100), mk(32'hA002, 1, 2, 1, 11, 10, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("raw_first_even", instr_even, 32'hA001);
        chk("raw_first_odd", instr_odd, 32'h0);
        chk("raw_in_ready_low", 32'(in_ready), 32'd0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("raw_stall_%0d", k), 32'(stall), 32'd1);
        end
        @(negedge clk);
        chk("raw_issue_odd", instr_odd, 32'hA002);
        chk("raw_issue_fo", 32'(first_odd), 32'd1);
        chk("raw_issue_stall", 32'(stall), 32'd0);
        idle(10);

        // scoreboard carry-over: FX2 writes r3, reader arrives one cycle after issue
        drive(mk(32'hB001, 0, 4, 1, 3, 1, 0, 0, 3'b100), mk(32'hB002, 1, 2, 1, 4, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("carry_p1_even", instr_even, 32'hB001);
        chk("carry_p1_odd", instr_odd, 32'hB002);
        chk("carry_ready_idle", 32'(in_ready), 32'd1);
        drive(mk(32'hB003, 0, 2, 1, 14, 3, 0, 0, 3'b100), mk(32'hB004, 1, 2, 1, 15, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("carry_stall_%0d", k), 32'(stall), 32'd1);
            if (k == 0) chk("carry_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("carry_p2_even", instr_even, 32'hB003);
        chk("carry_p2_odd", instr_odd, 32'hB004);
        chk("carry_p2_stall", 32'(stall), 32'd0);
        idle(10);

        // WAW split: younger latency wins even though it is shorter
        drive(mk(32'hC001, 0, 7, 1, 8, 1, 0, 0, 3'b100), mk(32'hC002, 1, 2, 1, 8, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("waw_even", instr_even, 32'hC001);
        chk("waw_sb8_first", 32'(dut.sb_cnt[8]), 32'd7);
        @(negedge clk);
        chk("waw_odd", instr_odd, 32'hC002);
        chk("waw_fo", 32'(first_odd), 32'd1);
        chk("waw_sb8_final", 32'(dut.sb_cnt[8]), 32'd2);
        idle(10);

        // flush while SINGLE is stalled on r12
        drive(mk(32'hD001, 1, 6, 1, 12, 1, 0, 0, 3'b100), mk(32'hD002, 0, 2, 1, 13, 12, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_odd", instr_odd, 32'hD001);
        chk("flush_pre_fo", 32'(first_odd), 32'd1);
        branch_taken = 1'b1;
        drive(mk(32'hD003, 0, 2, 1, 16, 1, 0, 0, 3'b100), mk(32'hD004, 1, 2, 1, 17, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        branch_taken = 1'b0;
        in_valid = 1'b0;
        chk("flush_even", instr_even, 32'h0);
        chk("flush_odd", instr_odd, 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_sb12", 32'(dut.sb_cnt[12]), 32'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("flush_quiet_even_%0d", k), instr_even, 32'h0);
        end
        chk("flush_sb12_drained", 32'(dut.sb_cnt[12]), 32'd0);
        idle(3);

        // flush in EMPTY drops the concurrent capture
        branch_taken = 1'b1;
        drive(mk(32'hD011, 0, 2, 1, 16, 1, 0, 0, 3'b100), mk(32'hD012, 1, 2, 1, 17, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        branch_taken = 1'b0;
        in_valid = 1'b0;
        chk("drop_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("drop_even_c1", instr_even, 32'h0);
        chk("drop_odd_c1", instr_odd, 32'h0);
        @(negedge clk);
        chk("drop_even_c2", instr_even, 32'h0);
        chk("drop_odd_c2", instr_odd, 32'h0);
        idle(10);

        // async reset during a stalled PAIR
        drive(mk(32'hE001, 0, 7, 1, 40, 1, 0, 0, 3'b100), mk(32'hE002, 1, 2, 1, 41, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        drive(mk(32'hE003, 0, 2, 1, 42, 40, 0, 0, 3'b100), mk(32'hE004, 1, 2, 1, 43, 2, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_even", instr_even, 32'hE001);
        chk("b2b_odd", instr_odd, 32'hE002);
        @(negedge clk);
        chk("arst_pre_stall", 32'(stall), 32'd1);
        chk("arst_pre_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_even", instr_even, 32'h0);
        chk("arst_odd", instr_odd, 32'h0);
        chk("arst_sb40", 32'(dut.sb_cnt[40]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(mk(32'hE005, 0, 2, 1, 44, 40, 0, 0, 3'b100), mk(32'hE006, 1, 2, 1, 45, 41, 0, 0, 3'b100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_even", instr_even, 32'hE005);
        chk("post_rst_odd", instr_odd, 32'hE006);
        chk("post_rst_stall", 32'(stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
